// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector: state width and the
// prefix-automaton transition used to build the next-state tables.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_W = 16;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } ovl_mode_e;

  function automatic int unsigned state_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Longest prefix of the pattern that is a suffix of (first k pattern bits, then b).
  function automatic int unsigned next_prefix(input logic [MAX_PAT_W-1:0] pattern,
                                              input int unsigned pat_w,
                                              input int unsigned k,
                                              input logic b);
    logic [MAX_PAT_W:0] s;
    int unsigned        best;
    logic               ok;
    s = '0;
    for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
      if (i < k) s[i] = pattern[pat_w-1-i];
    end
    s[k] = b;
    best = 0;
    for (int unsigned j = 1; j <= MAX_PAT_W; j++) begin
      if (j <= pat_w && j <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
          if (i < j && s[k+1-j+i] != pattern[pat_w-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with valid qualifier, overlap mode,
// synchronous clear and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap_en,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_params
    $fatal(1, "seq_detector_param: PAT_W must be 2..16 and CNT_W >= 1");
  end

  localparam int unsigned            SW       = state_w(PAT_W);
  localparam int unsigned            NCODE    = 2 ** SW;
  localparam logic [SW-1:0]          MATCH_ST = SW'(PAT_W);
  localparam logic [MAX_PAT_W-1:0]   PAT_EXT  = MAX_PAT_W'(PATTERN);

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] nxt0 [NCODE];
  logic [SW-1:0] nxt1 [NCODE];
  logic [SW-1:0] from_st, step_st;
  logic          cnt_inc;
  ovl_mode_e     mode;

  // Transition tables are elaboration constants; unused codes fall back to S0.
  for (genvar k = 0; k < NCODE; k++) begin : g_tab
    if (k <= PAT_W) begin : g_live
      assign nxt0[k] = SW'(next_prefix(PAT_EXT, PAT_W, k, 1'b0));
      assign nxt1[k] = SW'(next_prefix(PAT_EXT, PAT_W, k, 1'b1));
    end else begin : g_dead
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  assign mode = ovl_mode_e'(overlap_en);

  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    from_st = state_q;
    // Non-overlap discards the matched bits: leave MATCH as if from S0.
    if (state_q == MATCH_ST && mode == NON_OVERLAP) from_st = '0;
    step_st = x ? nxt1[from_st] : nxt0[from_st];
    if (clear) begin
      state_d = '0;
    end else if (x_valid) begin
      state_d = step_st;
      cnt_inc = (step_st == MATCH_ST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

  assign out = (state_q == MATCH_ST);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (cnt_inc),
    .clr_i  (clear),
    .count_o(match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four parameterisations share one stimulus
// stream and are checked against a bit-history model every cycle.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0, x_valid = 1'b0, overlap_en = 1'b0, clear = 1'b0;

  always #5 clk = ~clk;

  logic       o0, o1, o2, o3;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [3:0] c3;

  seq_detector_param u0 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .clear(clear), .out(o0), .match_cnt(c0));

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b101)) u1 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .clear(clear), .out(o1), .match_cnt(c1));

  seq_detector_param #(.CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .clear(clear), .out(o2), .match_cnt(c2));

  seq_detector_param #(.PAT_W(6), .PATTERN(6'b110110), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .clear(clear), .out(o3), .match_cnt(c3));

  localparam int ND = 4;
  int pw   [ND] = '{3, 3, 3, 6};
  int pat  [ND] = '{3, 5, 3, 54};
  int cmax [ND] = '{255, 255, 3, 15};

  // Model: valid bits since the last cut; a match is the last PAT_W bits equal to the pattern.
  logic [15:0] h   [ND];
  int          len [ND];
  int          mo  [ND];
  int          mc  [ND];

  int tests = 0;
  int fails = 0;

  function automatic void mreset();
    for (int i = 0; i < ND; i++) begin
      h[i] = '0; len[i] = 0; mo[i] = 0; mc[i] = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      mreset();
    end else if (x_valid) begin
      for (int i = 0; i < ND; i++) begin
        if (mo[i] != 0 && !overlap_en) begin
          h[i] = '0; len[i] = 0;
        end
        h[i] = {h[i][14:0], x};
        if (len[i] < 16) len[i]++;
        mo[i] = (len[i] >= pw[i] && ((int'(h[i]) & ((1 << pw[i]) - 1)) == pat[i])) ? 1 : 0;
        if (mo[i] != 0 && mc[i] < cmax[i]) mc[i]++;
      end
    end
  end

  function automatic int dut_out(input int i);
    case (i)
      0: return int'(o0);
      1: return int'(o1);
      2: return int'(o2);
      default: return int'(o3);
    endcase
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string nm, input int i, input int eo, input int ec);
    chk({nm, "_out"}, dut_out(i), eo);
    chk({nm, "_cnt"}, dut_cnt(i), ec);
    chk({nm, "_mdl_out"}, mo[i], eo);
    chk({nm, "_mdl_cnt"}, mc[i], ec);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("cmp%0d_out", i), dut_out(i), mo[i]);
      chk($sformatf("cmp%0d_cnt", i), dut_cnt(i), mc[i]);
    end
  end

  task automatic step(input logic xb, input logic v, input logic ov, input logic cl);
    x = xb; x_valid = v; overlap_en = ov; clear = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [11:0] s1, e1;
  logic [4:0]  s2, e2a, e2b;
  int          t4 [6] = '{1, 2, 3, 3, 3, 3};
  logic        ov_r;

  initial begin
    @(negedge clk);
    for (int i = 0; i < ND; i++) lit($sformatf("reset%0d", i), i, 0, 0);
    rst_n = 1'b1;

    // 011 non-overlap stream
    do_clear();
    s1 = 12'b011110100011;
    e1 = 12'b001000000001;
    for (int i = 0; i < 12; i++) begin
      step(s1[11-i], 1'b1, 1'b0, 1'b0);
      chk($sformatf("t1_bit%0d", i + 1), int'(o0), int'(e1[11-i]));
    end
    lit("t1_end", 0, 1, 2);

    // 101 overlap vs non-overlap
    s2 = 5'b10101; e2a = 5'b00101; e2b = 5'b00100;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      step(s2[4-i], 1'b1, 1'b1, 1'b0);
      chk($sformatf("t2ov_bit%0d", i + 1), int'(o1), int'(e2a[4-i]));
    end
    lit("t2ov_end", 1, 1, 2);
    do_clear();
    for (int i = 0; i < 5; i++) begin
      step(s2[4-i], 1'b1, 1'b0, 1'b0);
      chk($sformatf("t2no_bit%0d", i + 1), int'(o1), int'(e2b[4-i]));
    end
    lit("t2no_end", 1, 0, 1);

    // valid gaps
    do_clear();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
      lit("t3_gap", 0, 0, 0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("t3_match", 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'b0);
      lit("t3_idle", 0, 1, 1);
    end

    // saturation at CNT_W=2
    do_clear();
    for (int g = 0; g < 6; g++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      lit($sformatf("t4_grp%0d", g + 1), 2, 1, t4[g]);
    end

    // asynchronous reset mid-cycle from S2
    do_clear();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("t5_pre", 0, 0, 1);
    mid_reset();
    for (int i = 0; i < ND; i++) lit($sformatf("t5_async%0d", i), i, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("t5_restart", 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("t5_match", 0, 1, 1);

    // clear wins over a completing match
    do_clear();
    for (int g = 0; g < 5; g++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    lit("t6_pre", 0, 1, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    lit("t6_clear", 0, 0, 0);

    // randomized traffic, checked every cycle by the compare process
    ov_r = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(7) == 0) ov_r = ~ov_r;
      step(1'($urandom_range(1)), ($urandom_range(3) != 0), ov_r, ($urandom_range(40) == 0));
      if ($urandom_range(300) == 0) begin
        mid_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
